fixed_sqrt_v2: RTL and testbench



---
 rtl/fixed_sqrt_v2.sv | 118 +++++++++++
 tb/tb_fixed_sqrt_v2.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/fixed_sqrt_v2.sv
// fixed_sqrt_v2: iterative Q17.14 square root, one result bit per clock.
// Restoring shift-subtract over a 48-bit zero-extended radicand (rad << 14).
// Negative radicands produce a root of zero with the normal latency.
//
// state | meaning
// IDLE  | waiting for strobe
// BUSY  | one root bit per cycle, counter 23 down to 0
// DONE  | output register written on leaving; accepts a new strobe
module fixed_sqrt_v2 #(
  parameter int FRAC_BITS = 14,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe,
  input  logic [WIDTH-1:0] rad,
  output logic [WIDTH-1:0] root,
  output logic             valid
);

  localparam int RAD_W = WIDTH + FRAC_BITS + 2;
  localparam int ROOT_W = RAD_W / 2;
  localparam logic [4:0] ITER_LAST = 5'(ROOT_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [RAD_W-1:0]  r_rem;
  logic [RAD_W-1:0]  r_shf;
  logic [ROOT_W-1:0] r_part;
  logic [4:0]        r_cnt;

  logic [RAD_W-1:0]  w_rem_sh;
  logic [RAD_W-1:0]  w_trial;
  logic [RAD_W-1:0]  w_rem_nx;
  logic [ROOT_W-1:0] w_part_nx;
  logic              w_ge;
  logic              w_load;
  logic              w_fin;

  // One restoring iteration: bring down two radicand bits, try (root<<2)|1.
  always_comb begin
    w_rem_sh  = {r_rem[RAD_W-3:0], r_shf[RAD_W-1 -: 2]};
    w_trial   = RAD_W'({r_part, 2'b01});
    w_ge      = (w_rem_sh >= w_trial);
    w_rem_nx  = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    w_part_nx = {r_part[ROOT_W-2:0], w_ge};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic; DONE accepts a strobe just like IDLE so there is no bubble.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  w_state_nx = strobe ? S_BUSY : S_IDLE;
      S_BUSY:  w_state_nx = (r_cnt == 5'd0) ? S_DONE : S_BUSY;
      S_DONE:  w_state_nx = strobe ? S_BUSY : S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Control decode from the current state.
  always_comb begin
    w_load = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = strobe;
      S_DONE: begin
        w_load = strobe;
        w_fin  = 1'b1;
      end
      default: begin
        w_load = 1'b0;
        w_fin  = 1'b0;
      end
    endcase
  end

  // Datapath: latch the radicand on accept, iterate while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem  <= '0;
      r_shf  <= '0;
      r_part <= '0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_rem  <= '0;
      r_part <= '0;
      r_cnt  <= ITER_LAST;
      if (rad[WIDTH-1]) r_shf <= '0;
      else              r_shf <= {2'b00, rad, {FRAC_BITS{1'b0}}};
    end else if (r_state == S_BUSY) begin
      r_rem  <= w_rem_nx;
      r_part <= w_part_nx;
      r_shf  <= {r_shf[RAD_W-3:0], 2'b00};
      r_cnt  <= r_cnt - 5'd1;
    end
  end

  // Output register: written (and valid pulsed) on the edge that leaves DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      root  <= '0;
      valid <= 1'b0;
    end else begin
      valid <= w_fin;
      if (w_fin) root <= WIDTH'(r_part);
    end
  end

endmodule

// File: tb/tb_fixed_sqrt_v2.sv
// Self-checking bench for fixed_sqrt_v2: behavioural model plus directed literals.
module tb_fixed_sqrt_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic [31:0] rad;
  logic [31:0] root;
  logic        valid;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  bit chk_en  = 1'b0;

  // model state
  int          m_left = 0;
  logic [31:0] m_pend = '0;
  logic [31:0] exp_root = '0;
  logic        exp_valid = 1'b0;

  fixed_sqrt_v2 dut (
    .clk    (clk),
    .reset  (reset),
    .strobe (strobe),
    .rad    (rad),
    .root   (root),
    .valid  (valid)
  );

  always #5 clk = ~clk;

  function automatic longint unsigned isqrt(input longint unsigned v);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = 64'd16777216;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= v) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  function automatic logic [31:0] ref_root(input logic [31:0] r);
    longint unsigned v;
    if (r[31]) return 32'd0;
    v = longint'(r) * 64'd16384;
    return 32'(isqrt(v));
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a request is taken whenever no result is pending,
  // and its answer appears 25 edges later.
  always @(posedge clk) begin
    if (reset) begin
      m_left    = 0;
      exp_root  = '0;
      exp_valid = 1'b0;
    end else begin
      exp_valid = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          exp_root  = m_pend;
          exp_valid = 1'b1;
        end
      end
      if (m_left == 0 && strobe) begin
        m_pend = ref_root(rad);
        m_left = 25;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid_vs_model", {31'd0, valid}, {31'd0, exp_valid});
      check("root_vs_model", root, exp_root);
      if (valid) n_valid++;
    end
  end

  task automatic issue(input logic [31:0] v);
    @(negedge clk);
    strobe = 1'b1;
    rad    = v;
    @(negedge clk);
    strobe = 1'b0;
    rad    = $urandom;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] want);
    int i;
    for (i = 0; i < 40; i++) begin
      if (valid) break;
      @(negedge clk);
    end
    if (i == 40) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: timeout waiting for valid, expected root %h", name, want);
    end else begin
      check(name, root, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    reset  = 1'b1;
    strobe = 1'b0;
    rad    = '0;
    idle(3);
    check("reset_root", root, 32'd0);
    check("reset_valid", {31'd0, valid}, 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    idle(2);

    base = n_valid;
    issue(32'h0000C000);
    wait_valid("sqrt_3", 32'h00006ED9);
    idle(30);
    check("sqrt_3_single_pulse", n_valid - base, 1);

    issue(32'h00010000);
    wait_valid("sqrt_4", 32'h00008000);
    issue(32'h00001000);
    wait_valid("sqrt_0p25", 32'h00002000);
    issue(32'h00000000);
    wait_valid("sqrt_0", 32'h00000000);
    issue(32'h7FFFFFFF);
    wait_valid("sqrt_max", 32'h005A8279);
    issue(32'hFFFFC000);
    wait_valid("sqrt_neg1", 32'h00000000);
    idle(5);

    base = n_valid;
    @(negedge clk);
    strobe = 1'b1;
    rad    = 32'h01E6C000;
    idle(250);
    strobe = 1'b0;
    idle(30);
    check("held_1947_count", n_valid - base, 10);
    check("held_1947_root", root, 32'h000B07FD);

    base = n_valid;
    issue(32'h00024000);
    idle(8);
    issue(32'h00040000);
    wait_valid("busy_ignore_9", 32'h0000C000);
    idle(30);
    check("busy_ignore_count", n_valid - base, 1);

    base = n_valid;
    issue(32'h00090000);
    idle(11);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_root", root, 32'd0);
    check("midreset_valid", {31'd0, valid}, 32'd0);
    idle(35);
    check("midreset_no_pulse", n_valid - base, 0);
    issue(32'h00010000);
    wait_valid("after_reset_4", 32'h00008000);
    idle(3);

    base = n_valid;
    @(negedge clk);
    strobe = 1'b1;
    for (int k = 0; k < 62500; k++) begin
      rad = $urandom & 32'h7FFFFFFF;
      @(negedge clk);
    end
    strobe = 1'b0;
    idle(30);
    check("random_count", n_valid - base, 2500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
